// File: rtl/branch_resolve_if.sv
// Resolve-side and training-side handshake bundle of the branch resolve unit.
// The unit takes the slave view; execute and the predictor take the master view.
interface branch_resolve_if;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_pc;
    logic        res_pred_taken;
    logic [63:0] res_pred_target;
    logic        res_taken;
    logic [63:0] res_target;

    logic        update_valid;
    logic        update_ready;
    logic [63:0] update_pc;
    logic        update_taken;
    logic [63:0] update_target;

    modport master (
        output res_valid, res_pc, res_pred_taken, res_pred_target, res_taken, res_target,
        input  res_ready,
        output update_ready,
        input  update_valid, update_pc, update_taken, update_target
    );

    modport slave (
        input  res_valid, res_pc, res_pred_taken, res_pred_target, res_taken, res_target,
        output res_ready,
        input  update_ready,
        output update_valid, update_pc, update_taken, update_target
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves executed branches: one-cycle redirect on mispredict, saturating
// mispredict counter, and a FIFO of outcomes drained to the predictor's training port.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [63:0]      pc_q  [DEPTH];
    logic             tkn_q [DEPTH];
    logic [63:0]      tgt_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic             redir_vld_q, redir_vld_d;
    logic [63:0]      redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             empty, full, push, pop, mispredict;
    logic [63:0]      next_pc;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = !empty && bus.update_ready;
    assign push  = bus.res_valid && bus.res_ready;

    assign next_pc    = bus.res_taken ? bus.res_target : bus.res_pc + 64'd4;
    assign mispredict = (bus.res_pred_taken != bus.res_taken) ||
                        (bus.res_taken && (bus.res_pred_target != bus.res_target));

    assign bus.res_ready     = !full || pop;
    assign bus.update_valid  = !empty;
    assign bus.update_pc     = pc_q[rd_ptr_q[AW-1:0]];
    assign bus.update_taken  = tkn_q[rd_ptr_q[AW-1:0]];
    assign bus.update_target = tgt_q[rd_ptr_q[AW-1:0]];

    assign redirect_valid   = redir_vld_q;
    assign redirect_pc      = redir_pc_q;
    assign mispredict_count = cnt_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        redir_vld_d = push && mispredict;
        redir_pc_d  = redir_pc_q;
        cnt_d       = cnt_q;
        if (push && mispredict) begin
            redir_pc_d = next_pc;
            cnt_d      = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tkn_q[i] <= 1'b0;
                tgt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            cnt_q       <= cnt_d;
            if (push) begin
                pc_q[wr_ptr_q[AW-1:0]]  <= bus.res_pc;
                tkn_q[wr_ptr_q[AW-1:0]] <= bus.res_taken;
                tgt_q[wr_ptr_q[AW-1:0]] <= next_pc;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed test-plan cases, a mid-stream
// reset, randomized traffic, and a narrow-counter instance for saturation.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_resolve_if bus ();
    branch_resolve_if bus2 ();

    logic        rv, rv2;
    logic [63:0] rpc, rpc2;
    logic [31:0] cnt;
    logic [3:0]  cnt4;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .redirect_valid(rv), .redirect_pc(rpc), .mispredict_count(cnt)
    );

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .redirect_valid(rv2), .redirect_pc(rpc2), .mispredict_count(cnt4)
    );

    typedef struct {
        logic [63:0] pc;
        logic        taken;
        logic [63:0] tgt;
    } upd_t;

    typedef struct {
        int          cyc;
        logic [63:0] pc;
    } red_t;

    upd_t        upd_q[$];
    red_t        red_q[$];
    logic [31:0] exp_cnt = '0;
    logic [63:0] last_rpc = '0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          pend = 1'b0;
    bit          pend_mis = 1'b0;
    upd_t        pend_u;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic t, input logic [63:0] tgt);
        return t ? tgt : pc + 64'd4;
    endfunction

    function automatic bit ref_mis(input logic pt, input logic [63:0] ptgt, input logic t, input logic [63:0] tgt);
        if (pt && !t) return 1'b1;
        if (!pt && t) return 1'b1;
        return t && (ptgt != tgt);
    endfunction

    // Fold the accept decided last cycle into the expected queues.
    task automatic commit();
        red_t r;
        if (pend) begin
            upd_q.push_back(pend_u);
            if (pend_mis) begin
                r.cyc = cyc;
                r.pc  = pend_u.tgt;
                red_q.push_back(r);
                if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
            end
            pend = 1'b0;
        end
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input logic pt, input logic [63:0] ptgt,
                         input logic t, input logic [63:0] tgt, input bit ur);
        @(posedge clk);
        #1;
        commit();
        bus.res_valid       = v;
        bus.res_pc          = pc;
        bus.res_pred_taken  = pt;
        bus.res_pred_target = ptgt;
        bus.res_taken       = t;
        bus.res_target      = tgt;
        bus.update_ready    = ur;
        @(negedge clk);
        if (v && bus.res_ready) begin
            pend     = 1'b1;
            pend_u.pc    = pc;
            pend_u.taken = t;
            pend_u.tgt   = ref_next(pc, t, tgt);
            pend_mis = ref_mis(pt, ptgt, t, tgt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic reset_checks();
        check("rst_res_ready", bus.res_ready, 1);
        check("rst_update_valid", bus.update_valid, 0);
        check("rst_redirect_valid", rv, 0);
        check("rst_redirect_pc", rpc, 0);
        check("rst_count", cnt, 0);
        check("rst_update_pc", bus.update_pc, 0);
        check("rst_update_taken", bus.update_taken, 0);
        check("rst_update_target", bus.update_target, 0);
    endtask

    // Monitor: compares every observable output against the scoreboard each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_ready, exp_red;
            exp_ready = (upd_q.size() < DEPTH) || (upd_q.size() > 0 && bus.update_ready);
            check("res_ready", bus.res_ready, exp_ready);
            check("update_valid", bus.update_valid, upd_q.size() > 0);
            if (upd_q.size() > 0) begin
                check("update_pc", bus.update_pc, upd_q[0].pc);
                check("update_taken", bus.update_taken, upd_q[0].taken);
                check("update_target", bus.update_target, upd_q[0].tgt);
                if (bus.update_ready) void'(upd_q.pop_front());
            end
            exp_red = (red_q.size() > 0) && (red_q[0].cyc == cyc);
            check("redirect_valid", rv, exp_red);
            if (exp_red) begin
                last_rpc = red_q[0].pc;
                void'(red_q.pop_front());
            end else if (red_q.size() > 0 && red_q[0].cyc < cyc) begin
                void'(red_q.pop_front());
            end
            check("redirect_pc", rpc, last_rpc);
            check("mispredict_count", cnt, exp_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pc, tgt, ptgt;
        logic        t, pt;
        bit          v, ur;
        int          budget;

        rst_n = 1'b0;
        bus.res_valid = 0; bus.res_pc = 0; bus.res_pred_taken = 0; bus.res_pred_target = 0;
        bus.res_taken = 0; bus.res_target = 0; bus.update_ready = 1;
        bus2.res_valid = 0; bus2.res_pc = 0; bus2.res_pred_taken = 0; bus2.res_pred_target = 0;
        bus2.res_taken = 0; bus2.res_target = 0; bus2.update_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // Narrow counter: 17 mispredicts must saturate at 15.
        @(posedge clk);
        #1;
        bus2.res_valid = 1; bus2.res_pred_taken = 1; bus2.res_taken = 0; bus2.res_pc = 64'h100;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("sat_count", cnt4, (i < 15) ? i : 15);
        end
        bus2.res_valid = 0;

        drive(1, 64'h1000, 1, 64'h2000, 1, 64'h2000, 1);
        idle(2);
        drive(1, 64'h1000, 1, 64'h0, 0, 64'h0, 1);
        idle(2);
        drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h40, 1, 64'h80, 1);
        drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h40, 0, 64'h1234, 1);
        idle(2);

        // Fill with the predictor stalled, then stream with one pop and one push per cycle.
        for (int i = 0; i < 5; i++) drive(1, 64'h3000 + 64'(i * 16), 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 64'h4000 + 64'(i * 16), 1, 64'h5000, 1, 64'h5000 + 64'(i), 1);
        idle(6);

        // Reset with queued entries and a redirect in flight.
        drive(1, 64'h6000, 0, 0, 0, 0, 0);
        drive(1, 64'h7000, 0, 0, 1, 64'h9000, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        pend = 1'b0;
        bus.res_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        upd_q.delete();
        red_q.delete();
        exp_cnt = '0;
        last_rpc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            ur  = ($urandom_range(0, 3) != 0);
            pc  = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            t   = 1'($urandom_range(0, 1));
            tgt = {$urandom, $urandom};
            pt  = ($urandom_range(0, 1) != 0) ? t : !t;
            ptgt = ($urandom_range(0, 9) < 7) ? tgt : {$urandom, $urandom};
            drive(v, pc, pt, ptgt, t, tgt, ur);
        end

        budget = 0;
        while ((upd_q.size() > 0 || pend) && budget < 20) begin
            idle(1);
            budget++;
        end
        idle(2);
        check("drain_update_queue_empty", 64'(upd_q.size()), 0);
        check("drain_redirect_queue_empty", 64'(red_q.size()), 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Back-end companion to the fetch-side branch predictor: accepts resolved branches from the execute stage, detects mispredictions against the prediction carried down the pipe, and issues a one-cycle front-end redirect. It also buffers the resolved outcomes in a small FIFO and drains them, one per cycle, onto the predictor's training port (`update_valid` / `update_pc` / `update_taken` / `update_target`). A saturating mispredict counter is exposed for performance monitoring.

## Interface
- `DEPTH`, 4, update FIFO entries; power of two, ≥2.
- `CNT_W`, 32, mispredict counter width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `res_valid`  in  1  execute presents a resolved branch.
- `res_ready`  out  1  unit can accept this cycle.
- `res_pc`  in  64  branch PC.
- `res_pred_taken`  in  1  direction predicted at fetch.
- `res_pred_target`  in  64  target predicted at fetch.
- `res_taken`  in  1  actual direction.
- `res_target`  in  64  actual taken target; ignored when `res_taken`=0.
- `redirect_valid`  out  1  one-cycle pulse: flush front end and refetch.
- `redirect_pc`  out  64  correct next PC.
- `update_valid`  out  1  training entry available (FIFO non-empty).
- `update_ready`  in  1  predictor consumes entry; tie high if the predictor never stalls.
- `update_pc`  out  64  head entry PC.
- `update_taken`  out  1  head entry direction.
- `update_target`  out  64  head entry next PC.
- `mispredict_count`  out  CNT_W  saturating count of detected mispredictions.

## Operation
- Accept is `res_valid && res_ready`. When `res_valid` is low, the `res_*` inputs are don't-care.
- `next_pc = res_taken ? res_target : res_pc + 4`. The add is 64-bit modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
- A mispredict is `(res_pred_taken != res_taken) || (res_taken && res_pred_target != res_target)`. A predicted-taken/actual-not-taken branch is always a mispredict, regardless of target.
- On an accepted mispredict:
  - register `redirect_valid`=1 and `redirect_pc`=`next_pc` for exactly one cycle.
  - increment `mispredict_count`; it holds at all-ones and never wraps.
- On a correctly predicted accept, `redirect_valid` stays 0 and `redirect_pc` holds its last value.
- Every accept, mispredicted or not, enqueues {`res_pc`, `res_taken`, `next_pc`} at the FIFO tail.
- FIFO storage and pointers:
  - circular buffer with `log2(DEPTH)+1`-bit read/write pointers.
  - empty when the pointers are equal; full when the LSBs are equal and the MSBs differ.
- `update_*` are driven directly from the head entry's register storage, with no extra stage. Pop is `update_valid && update_ready`.
- `update_valid` = !empty. While `update_valid` is high and `update_ready` is low, the `update_*` outputs are held stable.
- `res_ready` = !full || pop. Push and pop on a full FIFO in the same cycle are legal; the count is unchanged and pointers advance.
- Push and pop on an empty FIFO:
  - the pop cannot occur because `update_valid`=0.
  - the push lands and the entry is visible next cycle.
- The unit does not squash younger resolutions. Execute stops sending wrong-path branches after a redirect.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, `update_valid`=0, `res_ready`=1, `redirect_valid`=0, `redirect_pc`=0, `mispredict_count`=0. `update_pc`/`update_target`/`update_taken` read as 0 (storage cleared).
- A reset asserted mid-stream discards all queued entries and any pending redirect in the same instant.
- Accept in cycle N:
  - `redirect_valid` pulses in cycle N+1.
  - the entry appears on `update_*` in N+1 if the FIFO was empty, otherwise after the older entries drain.
  - the counter value reflects the mispredict in N+1.
- Back-to-back mispredicts in N and N+1 give redirect pulses in N+1 and N+2. `redirect_pc` follows each.
- Sustained throughput is 1 resolution/cycle when `update_ready`=1. `res_ready` is combinational from full and pop.

## Test plan
- Reset, then idle → `res_ready`=1, `update_valid`=0, `redirect_valid`=0, `mispredict_count`=0.
- Accept pc=0x1000, pred_taken=1/pred_target=0x2000, taken=1/target=0x2000 → no redirect; next cycle `update_valid`=1 with pc 0x1000, taken 1, target 0x2000.
- Direction mispredict:
  - Stimulus: accept pc=0x1000, pred_taken=1, taken=0.
  - Response: next cycle `redirect_valid`=1 for one cycle, `redirect_pc`=0x1004, `mispredict_count`=1, `update_target`=0x1004.
- Target mispredict at wrap:
  - Stimulus: accept pc=0xFFFF_FFFF_FFFF_FFFC, pred_taken=1/0x40, taken=1/0x80; then accept the same pc with taken=0.
  - Response: first redirect to 0x80; second `redirect_pc`=0x0.
- `update_ready`=0 while pushing 4 branches → `res_ready`=0 after the 4th. Then with `update_ready`=1 and `res_valid`=1 held, one pop and one push occur per cycle, with order preserved.
- Force the counter to all-ones−1 (CNT_W=4 build), then issue 3 mispredicts → counter reads 15 and stays at 15.
